// File: rtl/glove_region_detector.sv
// Chroma-key glove locator: classifies pixels in YCbCr space, counts matches per
// vertical strip and raises debounced red/green/blue/yellow presence flags each frame.
module glove_region_detector #(
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480,
  parameter int         REGION_W   = 160,
  parameter logic [7:0] Y_MIN      = 8'd40,
  parameter logic [7:0] CB_MIN     = 8'd77,
  parameter logic [7:0] CB_MAX     = 8'd127,
  parameter logic [7:0] CR_MIN     = 8'd133,
  parameter logic [7:0] CR_MAX     = 8'd173,
  parameter int         PIX_THRESH = 2000,
  parameter int         DEBOUNCE   = 3,
  parameter int         CNT_W      = 17
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pixel_valid,
  input  logic [9:0] i_x_pos,
  input  logic [9:0] i_y_pos,
  input  logic [7:0] i_y_in,
  input  logic [7:0] i_cb_in,
  input  logic [7:0] i_cr_in,
  input  logic       i_frame_end,
  output logic       o_red_flag,
  output logic       o_green_flag,
  output logic       o_blue_flag,
  output logic       o_yellow_flag,
  output logic       o_flags_valid
);

  localparam logic [9:0]       LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0]       LP_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0]       LP_EDGE1    = 10'(REGION_W);
  localparam logic [9:0]       LP_EDGE2    = 10'(2 * REGION_W);
  localparam logic [9:0]       LP_EDGE3    = 10'(3 * REGION_W);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LP_THRESH   = CNT_W'(PIX_THRESH);
  localparam logic [2:0]       LP_DEBOUNCE = 3'(DEBOUNCE);

  logic             w_in_frame;
  logic             w_colour_ok;
  logic             w_match;
  logic [1:0]       w_strip;

  logic             r_s1_match;
  logic [1:0]       r_s1_strip;
  logic             r_s1_fe;

  logic [CNT_W-1:0] r_cnt      [4];
  logic [CNT_W-1:0] w_cnt_next [4];
  logic             r_s2_fe;

  logic [3:0]       r_hit;
  logic             r_eval;

  logic [2:0]       r_d        [4];
  logic [2:0]       w_d_next   [4];
  logic [3:0]       r_flag;
  logic [3:0]       w_flag_next;
  logic             r_flags_valid;

  assign w_in_frame  = i_pixel_valid && (i_x_pos < LP_H_ACTIVE) && (i_y_pos < LP_V_ACTIVE);
  assign w_colour_ok = (i_y_in >= Y_MIN)
                    && (i_cb_in >= CB_MIN) && (i_cb_in <= CB_MAX)
                    && (i_cr_in >= CR_MIN) && (i_cr_in <= CR_MAX);
  assign w_match     = w_in_frame && w_colour_ok;

  // Strip lookup by comparison against the three strip edges.
  always_comb begin
    w_strip = 2'd3;
    if (i_x_pos < LP_EDGE1) begin
      w_strip = 2'd0;
    end else if (i_x_pos < LP_EDGE2) begin
      w_strip = 2'd1;
    end else if (i_x_pos < LP_EDGE3) begin
      w_strip = 2'd2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_match <= 1'b0;
      r_s1_strip <= 2'd0;
      r_s1_fe    <= 1'b0;
    end else begin
      r_s1_match <= w_match;
      r_s1_strip <= w_strip;
      r_s1_fe    <= i_frame_end;
    end
  end

  // While frame_end sits in S2 the counters already hold the final counts; the
  // S1 pixel arriving in that cycle belongs to the next frame and seeds the reload.
  always_comb begin
    w_cnt_next = r_cnt;
    for (int k = 0; k < 4; k++) begin
      if (r_s2_fe) begin
        w_cnt_next[k] = {{(CNT_W-1){1'b0}}, (r_s1_match && (r_s1_strip == 2'(k)))};
      end else if (r_s1_match && (r_s1_strip == 2'(k)) && (r_cnt[k] != LP_CNT_MAX)) begin
        w_cnt_next[k] = r_cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
      r_s2_fe <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_s2_fe <= r_s1_fe;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit  <= 4'd0;
      r_eval <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_hit[k] <= (r_cnt[k] >= LP_THRESH);
      end
      r_eval <= r_s2_fe;
    end
  end

  // A flag only toggles after DEBOUNCE consecutive frames that disagree with it;
  // any agreeing frame clears the run.
  always_comb begin
    w_d_next    = r_d;
    w_flag_next = r_flag;
    if (r_eval) begin
      for (int k = 0; k < 4; k++) begin
        if (r_hit[k] != r_flag[k]) begin
          if ((r_d[k] + 3'd1) == LP_DEBOUNCE) begin
            w_flag_next[k] = ~r_flag[k];
            w_d_next[k]    = 3'd0;
          end else begin
            w_d_next[k]    = r_d[k] + 3'd1;
          end
        end else begin
          w_d_next[k] = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_d[k] <= 3'd0;
      end
      r_flag        <= 4'd0;
      r_flags_valid <= 1'b0;
    end else begin
      r_d           <= w_d_next;
      r_flag        <= w_flag_next;
      r_flags_valid <= r_eval;
    end
  end

  assign o_red_flag    = r_flag[0];
  assign o_green_flag  = r_flag[1];
  assign o_blue_flag   = r_flag[2];
  assign o_yellow_flag = r_flag[3];
  assign o_flags_valid = r_flags_valid;

endmodule

// File: doc/glove_region_detector.md
# glove_region_detector

Per-frame chroma-key detector that locates the coloured glove in one of four vertical screen strips. It sits directly upstream of the overlay/drawing stage and drives its red/green/blue/yellow region flags. Each camera pixel is classified in YCbCr space, and matching pixels are counted per strip. At every frame end the counts are thresholded and debounced over consecutive frames.

## Interface
- H_ACTIVE, 640: active pixels per line; pixels with x_pos >= H_ACTIVE are ignored.
- V_ACTIVE, 480: active lines; pixels with y_pos >= V_ACTIVE are ignored.
- REGION_W, 160: strip width. Strips are 0:[0,160) red, 1:[160,320) green, 2:[320,480) blue, 3:[480,640) yellow.
- Y_MIN, 8'd40: minimum luma for a match.
- CB_MIN / CB_MAX, 8'd77 / 8'd127: inclusive Cb match window.
- CR_MIN / CR_MAX, 8'd133 / 8'd173: inclusive Cr match window.
- PIX_THRESH, 2000: matching-pixel count at or above which a strip is "hit" for a frame.
- DEBOUNCE, 3: consecutive frames needed to change a flag (1..7).
- CNT_W, 17: strip counter width; counters saturate at 2^CNT_W-1.
- clk, input, 1: pixel clock.
- rst_n, input, 1: asynchronous active-low reset.
- pixel_valid, input, 1: x_pos/y_pos/Y_in/Cb_in/Cr_in are valid this cycle.
- x_pos, input, 10: pixel column.
- y_pos, input, 10: pixel row.
- Y_in, Cb_in, Cr_in, input, 8 each: pixel colour.
- frame_end, input, 1: one-cycle pulse, asserted on or after the last pixel of a frame.
- red_flag, green_flag, blue_flag, yellow_flag, output, 1 each: debounced strip presence, one per strip 0..3.
- flags_valid, output, 1: one-cycle pulse when flags are re-evaluated.

## Operation
- Match condition: pixel_valid, x_pos < H_ACTIVE, y_pos < V_ACTIVE, Y_in >= Y_MIN, and Cb_in and Cr_in both inside their windows. All comparisons are unsigned and inclusive.
- Strip index comes from x_pos compared against REGION_W, 2·REGION_W and 3·REGION_W. No division is used.
- Pipeline:
  - S1 registers the match bit and the 2-bit strip index.
  - S2 increments the selected strip counter, saturating.
- frame_end travels through the same delay as pixels, so it stays aligned with them.
  - Every pixel with pixel_valid in the frame_end cycle, or earlier, counts toward the ending frame.
  - Pixels after that cycle count toward the next frame.
  - No pixel is lost or double-counted across the boundary.
- Evaluation edge, per strip:
  - hit = final count >= PIX_THRESH.
  - The strip counter reloads with 0, or with 1 if a next-frame pixel lands in the same cycle.
- Debounce, per strip, using a 3-bit counter d:
  - flag=0, hit: d+1. On reaching DEBOUNCE, flag←1 and d←0.
  - flag=0, miss: d←0.
  - flag=1, miss: d+1. On reaching DEBOUNCE, flag←0 and d←0.
  - flag=1, hit: d←0.
- Strips are independent; several flags may be high together. Priority among them is the consumer's concern.
- A frame_end with no preceding pixels evaluates as all-miss.

## Timing
- Reset (rst_n=0, asynchronous): all flags 0, flags_valid 0, strip counters 0, debounce counters 0, pipeline registers cleared.
- Reset mid-frame: the partial frame after release is counted normally from zero. No special handling.
- frame_end sampled at edge N: new flags and the flags_valid pulse are visible after edge N+3. The flags hold until the next evaluation.
- Back-to-back frame_end on consecutive cycles: each is evaluated separately; the second sees only the pixels between the two.
- Flags are registered outputs with no combinational path from the inputs.
- Throughput: one pixel per clk, with no stalls.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all flags and flags_valid are 0 immediately. After release with no frames, they stay 0.
- Red assert:
  - Stimulus: 3 frames, each with 2000 pixels at x=0..159, Y=100, Cb=100, Cr=150, then frame_end.
  - Required: red_flag=1 exactly 3 cycles after the third frame_end, with a flags_valid pulse. Other flags stay 0.
- Threshold edge: 1999 matching pixels in strip 1 for 5 frames -> green_flag stays 0. With 2000 pixels for 3 frames -> green_flag=1.
- Release and hysteresis:
  - Setup: yellow_flag=1.
  - Stimulus: miss, miss, hit, miss, miss, miss.
  - Required: yellow_flag drops only after the sixth frame.
- Boundaries:
  - Pixels at x=159 count for strip 0; x=160 counts for strip 1; x=640 or y=480 are ignored.
  - Cb=127 and Cr=173 match; Cb=128 does not.
- Frame seam: a matching pixel in the same cycle as frame_end counts for the ending frame. A pixel one cycle later counts for the next frame, checked through the per-frame hit count.
